// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset vector and fetch FSM encoding.
package cpu_pkg;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 16;

  localparam logic [15:0] RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_VALID = 2'd2
  } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/instruction_fetch_if.sv
// Fetch-side buses: instruction memory read port and decoder valid/ready handoff.
// master = fetch unit, slave = memory + decoder side.
interface instruction_fetch_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_word;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instr_word, instr_pc,
    input  mem_ready, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr_word, instr_pc,
    output mem_ready, mem_rdata, instr_ready
  );

endinterface : instruction_fetch_if

// File: rtl/instruction_pointer.sv
// Instruction pointer register: load has priority over increment, wraps naturally.
module instruction_pointer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_ip,
  input  logic              load_ip,
  input  logic [ADDR_W-1:0] ip_data_in,
  output logic [ADDR_W-1:0] ip_data_out
);

  // IP register: redirect load wins, otherwise step by one word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ip_data_out <= ADDR_W'(RESET_VECTOR);
    end else if (load_ip) begin
      ip_data_out <= ip_data_in;
    end else if (inc_ip) begin
      ip_data_out <= ip_data_out + 1'b1;
    end
  end

endmodule : instruction_pointer

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: reads IP, issues one memory read at a time,
// hands the word to the decoder and steers the IP (increment / redirect).
// REQ spends its first cycle latching the IP into mem_addr, then holds
// mem_req until mem_ready; this keeps the address behind the inc_ip pulse.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [ADDR_W-1:0] ip_data_out,
  output logic              inc_ip,
  output logic              load_ip,
  output logic [ADDR_W-1:0] ip_data_in,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  instruction_fetch_if.master bus
);

  fetch_state_t      state_q, state_d;
  logic              issued_q;   // address latched, read outstanding
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] word_q;
  logic              inc_q;      // increment owed for the word just captured
  logic              accept;

  assign accept = (state_q == FETCH_REQ) && issued_q && bus.mem_ready;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a redirect overrides every other transition.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    if (redirect_valid) begin
      state_d = run ? FETCH_REQ : FETCH_IDLE;
    end else begin
      unique case (state_q)
        FETCH_IDLE:  if (run) state_d = FETCH_REQ;
        FETCH_REQ:   if (accept) state_d = FETCH_VALID;
        FETCH_VALID: if (bus.instr_ready) state_d = run ? FETCH_REQ : FETCH_IDLE;
        default:     state_d = FETCH_IDLE;
      endcase
    end
  end

  // Request/capture datapath; data arriving with a redirect is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_q <= 1'b0;
      addr_q   <= '0;
      pc_q     <= '0;
      word_q   <= '0;
      inc_q    <= 1'b0;
    end else begin
      inc_q <= accept && !redirect_valid;
      if (redirect_valid) begin
        issued_q <= 1'b0;
      end else if (state_q == FETCH_REQ) begin
        if (!issued_q) begin
          issued_q <= 1'b1;
          addr_q   <= ip_data_out;
        end else if (bus.mem_ready) begin
          issued_q <= 1'b0;
          word_q   <= bus.mem_rdata;
          pc_q     <= addr_q;
        end
      end
    end
  end

  assign bus.mem_req     = issued_q;
  assign bus.mem_addr    = addr_q;
  assign bus.instr_valid = (state_q == FETCH_VALID);
  assign bus.instr_word  = word_q;
  assign bus.instr_pc    = pc_q;

  // Redirect cancels any owed increment so the IP sees exactly one command.
  assign inc_ip     = inc_q && !redirect_valid;
  assign load_ip    = redirect_valid && !reset;
  assign ip_data_in = load_ip ? redirect_addr : '0;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch + instruction_pointer + wait-state memory model.
// Reference model tracks the architectural PC, the word owed to the decoder
// and the increment owed to the IP; it is checked on every cycle.
module tb_instruction_fetch;
  import cpu_pkg::*;

  localparam int AW = CPU_ADDR_W;
  localparam int DW = CPU_DATA_W;

  logic          clk = 1'b0;
  logic          reset, ip_reset, run;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic [AW-1:0] ip_data_out, ip_data_in;
  logic          inc_ip, load_ip;

  instruction_fetch_if bus ();

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .ip_data_out    (ip_data_out),
    .inc_ip         (inc_ip),
    .load_ip        (load_ip),
    .ip_data_in     (ip_data_in),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .bus            (bus)
  );

  instruction_pointer u_ip (
    .clk         (clk),
    .reset       (ip_reset),
    .inc_ip      (inc_ip),
    .load_ip     (load_ip),
    .ip_data_in  (ip_data_in),
    .ip_data_out (ip_data_out)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [DW-1:0] mem_model [0:65535];
  int  wait_cfg = 0;       // <0: random 0..3 per request
  int  wait_cnt = 0;
  int  cur_wait = 0;
  bit  mem_busy = 0;

  always @(posedge clk) begin
    #1;
    if (bus.mem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        wait_cnt = 0;
        cur_wait = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
      end
      if (wait_cnt >= cur_wait) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_model[bus.mem_addr];
        mem_busy      = 0;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'($urandom);
        wait_cnt++;
      end
    end else begin
      mem_busy      = 0;
      bus.mem_ready = 1'($urandom_range(0, 1));   // must be ignored
      bus.mem_rdata = 16'($urandom);
    end
  end

  // ---------------- decoder model ----------------
  bit rdy_random = 0;
  bit rdy_force  = 1;

  always @(posedge clk) begin
    #1;
    bus.instr_ready = rdy_random ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // ---------------- reference model + compare ----------------
  logic [AW-1:0] model_pc = RESET_VECTOR;
  logic [AW-1:0] exp_pc   = '0;
  logic [AW-1:0] exp_ip;
  bit  have_word = 0, inc_pending = 0, prev_redirect = 0, prev_req = 0, accept;
  int  cycle = 0, cur_len = 0, n_inc = 0;
  logic [AW-1:0] req_addrs[$], deliv_pcs[$];
  logic [DW-1:0] deliv_words[$];
  int  req_lens[$], acc_times[$];

  always @(negedge clk) begin
    cycle++;
    if (reset) begin
      have_word = 0; inc_pending = 0; prev_redirect = 0; prev_req = 0; cur_len = 0;
    end else begin
      accept = bus.mem_req && bus.mem_ready;
      exp_ip = inc_pending ? 16'(model_pc - 16'd1) : model_pc;
      check("load_ip", load_ip, redirect_valid);
      if (redirect_valid) check("ip_data_in", ip_data_in, redirect_addr);
      check("inc_ip", inc_ip, inc_pending && !redirect_valid);
      check("inc_load_excl", inc_ip && load_ip, 0);
      check("ip_value", ip_data_out, exp_ip);
      check("instr_valid", bus.instr_valid, have_word);
      if (have_word) begin
        check("instr_pc", bus.instr_pc, exp_pc);
        check("instr_word", bus.instr_word, mem_model[exp_pc]);
      end
      if (bus.mem_req) begin
        check("mem_addr", bus.mem_addr, model_pc);
        check("one_in_flight", have_word, 0);
      end
      if (prev_redirect) check("req_after_redirect", bus.mem_req, 0);

      // event logs for the directed checks
      if (bus.mem_req && !prev_req) req_addrs.push_back(bus.mem_addr);
      if (bus.mem_req) cur_len++;
      else if (prev_req) begin req_lens.push_back(cur_len); cur_len = 0; end
      if (bus.instr_valid && bus.instr_ready) begin
        deliv_pcs.push_back(bus.instr_pc);
        deliv_words.push_back(bus.instr_word);
      end
      if (accept && !redirect_valid) acc_times.push_back(cycle);
      if (inc_ip) n_inc++;

      // advance the architectural model by this cycle's events
      if (redirect_valid) begin
        model_pc    = redirect_addr;
        have_word   = 0;
        inc_pending = 0;
      end else begin
        if (have_word && bus.instr_ready) have_word = 0;
        inc_pending = 0;
        if (accept) begin
          have_word   = 1;
          exp_pc      = model_pc;
          model_pc    = model_pc + 16'd1;
          inc_pending = 1;
        end
      end
      prev_redirect = redirect_valid;
      prev_req      = bus.mem_req;
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(inc_ip && load_ip))
    else $error("FAIL inc_load_excl assertion");

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [AW-1:0] a);
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic clear_logs();
    req_addrs.delete(); deliv_pcs.delete(); deliv_words.delete();
    req_lens.delete(); acc_times.delete(); n_inc = 0;
  endtask

  task automatic drain(input string name);
    run = 1'b0; rdy_random = 0; rdy_force = 1;
    repeat (16) tick();
    check({name, "_idle"}, {bus.mem_req, bus.instr_valid}, 0);
  endtask

  task automatic wait_deliv(input int target, input int budget, input string name);
    int k = 0;
    while (deliv_pcs.size() < target && k < budget) begin
      tick();
      k++;
    end
    check({name, "_timeout"}, deliv_pcs.size() >= target, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    for (int i = 0; i < 65536; i++) mem_model[i] = 16'($urandom);
    mem_model[16'h1000] = 16'hA5A5;
    mem_model[16'h2000] = 16'h1234;
    mem_model[16'h3500] = 16'hBEEF;
    mem_model[16'hFFFF] = 16'hF00D;

    reset = 1; ip_reset = 1; run = 0; redirect_valid = 0; redirect_addr = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0; bus.instr_ready = 1;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_instr_valid", bus.instr_valid, 0);
    check("rst_instr_word", bus.instr_word, 0);
    check("rst_instr_pc", bus.instr_pc, 0);
    check("rst_inc_ip", inc_ip, 0);
    check("rst_load_ip", load_ip, 0);
    check("rst_ip_data_in", ip_data_in, 0);
    @(posedge clk); #1;
    reset = 0; ip_reset = 0;

    // 1: zero-wait fetch from 0x1000, 3-cycle throughput
    wait_cfg = 0;
    redirect_to(16'h1000);
    clear_logs();
    run = 1;
    wait_deliv(3, 40, "t1");
    drain("t1");
    check("t1_req0", req_addrs[0], 16'h1000);
    check("t1_pc0", deliv_pcs[0], 16'h1000);
    check("t1_word0", deliv_words[0], 16'hA5A5);
    check("t1_req1", req_addrs[1], 16'h1001);
    check("t1_period", acc_times[1] - acc_times[0], 3);
    check("t1_inc_count", n_inc, acc_times.size());

    // 2: two wait states
    wait_cfg = 2;
    redirect_to(16'h1000);
    clear_logs();
    run = 1;
    wait_deliv(3, 60, "t2");
    drain("t2");
    for (int i = 0; i < 3; i++) begin
      check("t2_req_len", req_lens[i], 3);
      check("t2_pc", deliv_pcs[i], 16'h1000 + i);
    end
    check("t2_inc_count", n_inc, acc_times.size());

    // 3: decoder stall for 4 cycles
    wait_cfg = 0;
    rdy_force = 0;
    redirect_to(16'h2000);
    clear_logs();
    run = 1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (bus.instr_valid) found = 1;
    end
    check("t3_valid_seen", found, 1);
    for (int k = 0; k < 4; k++) begin
      check("t3_stall_valid", bus.instr_valid, 1);
      check("t3_stall_word", bus.instr_word, 16'h1234);
      check("t3_stall_pc", bus.instr_pc, 16'h2000);
      check("t3_stall_noreq", bus.mem_req, 0);
      tick();
    end
    rdy_force = 1;
    wait_deliv(1, 20, "t3");
    drain("t3");
    check("t3_pc0", deliv_pcs[0], 16'h2000);

    // 4: redirect in the same cycle as mem_ready
    redirect_to(16'h3000);
    clear_logs();
    run = 1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #2;
      if (bus.mem_req && bus.mem_ready) found = 1;
    end
    check("t4_hit", found, 1);
    if (found) begin
      redirect_valid = 1; redirect_addr = 16'h3500;
      #1;
      check("t4_load_ip", load_ip, 1);
      check("t4_ip_data_in", ip_data_in, 16'h3500);
      check("t4_inc_ip", inc_ip, 0);
      tick();
      redirect_valid = 0;
    end
    wait_deliv(1, 30, "t4");
    drain("t4");
    check("t4_pc0", deliv_pcs[0], 16'h3500);
    check("t4_word0", deliv_words[0], 16'hBEEF);
    check("t4_req1", req_addrs[1], 16'h3500);

    // 5: wrap-around at 0xFFFF
    redirect_to(16'hFFFF);
    clear_logs();
    run = 1;
    wait_deliv(2, 30, "t5");
    drain("t5");
    check("t5_pc0", deliv_pcs[0], 16'hFFFF);
    check("t5_word0", deliv_words[0], 16'hF00D);
    check("t5_pc1", deliv_pcs[1], 16'h0000);
    check("t5_req1", req_addrs[1], 16'h0000);

    // 6: reset mid-request, held two cycles, IP itself not reset
    wait_cfg = 3;
    redirect_to(16'h4000);
    clear_logs();
    run = 1;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (bus.mem_req) found = 1;
    end
    check("t6_req_seen", found, 1);
    @(posedge clk); #2;
    reset = 1;
    #1;
    check("t6_rst_mem_req", bus.mem_req, 0);
    check("t6_rst_valid", bus.instr_valid, 0);
    check("t6_rst_inc", inc_ip, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 0;
    wait_deliv(1, 40, "t6");
    drain("t6");
    check("t6_req_restart", req_addrs[1], 16'h4000);
    check("t6_pc0", deliv_pcs[0], 16'h4000);

    // 7: randomized traffic
    wait_cfg = -1;
    rdy_random = 1;
    clear_logs();
    for (int k = 0; k < 3000; k++) begin
      tick();
      run = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1;
        redirect_addr  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFD + $urandom_range(0, 2))
                                                     : 16'($urandom);
      end else begin
        redirect_valid = 0;
      end
    end
    redirect_valid = 0;
    drain("t7");
    check("t7_activity", deliv_pcs.size() > 100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Sequencer on the other end of the instruction pointer's control interface. It reads the current IP, issues a memory read at that address, and hands the fetched word to the decoder over a valid/ready handshake. It drives inc_ip after each accepted fetch and load_ip on branch redirects. It sits between instruction_pointer, the instruction memory port and the decode stage.

Parameters:
ADDR_W, 16, address width; must equal the IP width
DATA_W, 16, instruction word width

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
run  input  1  level; 1 = fetching enabled, 0 = stop after the current fetch
ip_data_out  input  ADDR_W  current IP value from instruction_pointer
inc_ip  output  1  one-cycle pulse; IP increments at the next edge
load_ip  output  1  one-cycle pulse; IP loads ip_data_in at the next edge
ip_data_in  output  ADDR_W  redirect target, valid while load_ip=1
mem_req  output  1  read request, held until mem_ready
mem_addr  output  ADDR_W  read address, equals the IP latched at request start
mem_ready  input  1  memory returns data this cycle (meaningful only while mem_req=1)
mem_rdata  input  DATA_W  read data, sampled when mem_req && mem_ready
instr_valid  output  1  fetched word available to the decoder
instr_ready  input  1  decoder accepts the word this cycle
instr_word  output  DATA_W  fetched instruction
instr_pc  output  ADDR_W  address instr_word was fetched from
redirect_valid  input  1  branch/jump taken; abandon the current fetch
redirect_addr  input  ADDR_W  new IP target

Behaviour:
- Reset values: state=IDLE; inc_ip=0, load_ip=0, ip_data_in=0, mem_req=0, mem_addr=0, instr_valid=0, instr_word=0, instr_pc=0.
- States: IDLE, REQ, VALID.
- IDLE transitions:
  - run=1 -> REQ next cycle.
  - Outputs are all inactive.
- REQ:
  - Entry: mem_addr is registered from ip_data_out.
  - Held: mem_req=1 and mem_addr stays constant until mem_ready.
  - On mem_req && mem_ready: instr_word<=mem_rdata, instr_pc<=mem_addr, inc_ip pulses in the following cycle, state->VALID.
- VALID:
  - instr_valid=1; instr_word and instr_pc are stable while instr_ready=0.
  - On instr_ready: if run=1 -> REQ, otherwise -> IDLE. instr_valid falls the next cycle.
  - The next request's address is taken no earlier than the cycle after the inc_ip pulse, so it sees the incremented IP.
- Throughput: at most one fetch in flight. With zero-wait memory and an always-ready decoder, one instruction every 3 cycles.
- Redirect (redirect_valid=1 in any state) has priority over everything:
  - load_ip=1 and ip_data_in=redirect_addr for exactly that cycle; inc_ip is forced 0.
  - Any pending inc_ip pulse is cancelled.
  - mem_req is deasserted the next cycle, and data returned in the redirect cycle is discarded.
  - instr_valid is cleared.
  - State -> REQ if run=1 (new address sampled next cycle, after IP loads), else IDLE.
- inc_ip and load_ip are never high in the same cycle (assertion in bench).
- A redirect in VALID with instr_ready=1 in the same cycle: the word counts as consumed, and the redirect still applies.
- run falling mid-REQ: the fetch completes, the word is delivered, then IDLE.
- Wrap-around: IP 0xFFFF increments to 0x0000 inside instruction_pointer. The fetch treats the address as opaque, with no special case.
- Reset asserted mid-fetch: all outputs return to reset values asynchronously, and the in-flight memory response is ignored.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding localparams FETCH_IDLE/FETCH_REQ/FETCH_VALID;
  - ADDR_W/DATA_W defaults shared with instruction_pointer;
  - RESET_VECTOR constant (16'h0000).
- No sub-module: single FSM plus output registers.
- Bench instantiates instruction_fetch + instruction_pointer together + a behavioural memory model with configurable wait states.

Test Plan:
1. Reset with IP loaded to 16'h1000, run=1, zero-wait memory holding mem[1000]=16'hA5A5 -> mem_addr=1000; instr_valid with instr_word=A5A5, instr_pc=1000; inc_ip single pulse; next mem_addr=1001.
2. Memory with 2 wait states -> mem_req held 3 cycles with mem_addr constant; exactly one inc_ip per fetch; instr_pc sequence 1000,1001,1002.
3. Decoder stalls (instr_ready=0 for 4 cycles) -> instr_valid/instr_word stable; no new mem_req until accepted.
4. redirect_valid with redirect_addr=16'h3500 during REQ, same cycle as mem_ready -> load_ip=1, ip_data_in=3500, inc_ip=0; stale data never appears on instr_valid; next fetch at 3500.
5. IP=16'hFFFF fetch -> instr_pc=FFFF, next mem_addr=0000.
6. Reset asserted mid-REQ and held 2 cycles -> mem_req=0, instr_valid=0 immediately; after release with run=1, the fetch restarts from the current IP.
